// File: rtl/bicubic_sched_pkg.sv
// Shared constants, state/owner encodings and the tag layout used by the
// bicubic tap arbiter and its tag delay line.
package bicubic_sched_pkg;

    localparam int DEF_LATENCY = 3;
    localparam int DEF_BURST   = 4;

    localparam int A_W   = 40;
    localparam int B_W   = 38;
    localparam int C_W   = 28;
    localparam int D_W   = 18;
    localparam int R_W   = 17;
    localparam int TAP_W = 2;
    localparam int TAG_W = 1 + 1 + TAP_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_X = 2'd1,
        ST_OWN_Y = 2'd2
    } sched_state_t;

    typedef enum logic {
        OWNER_X = 1'b0,
        OWNER_Y = 1'b1
    } owner_t;

    typedef struct packed {
        logic             valid;
        owner_t           owner;
        logic [TAP_W-1:0] tap;
    } tag_t;

    function automatic logic [TAG_W-1:0] make_tag(input logic valid, input owner_t owner,
                                                  input logic [TAP_W-1:0] tap);
        tag_t t;
        t.valid = valid;
        t.owner = owner;
        t.tap   = tap;
        return t;
    endfunction

endpackage

// File: rtl/sched_tag_pipe.sv
// Fixed-length delay line that carries {valid, owner, tap} alongside the
// external multiply-add datapath so results can be routed to their owner.
module sched_tag_pipe
    import bicubic_sched_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out,
    output logic             any_valid
);

    logic [TAG_W-1:0] stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[LATENCY-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | stage[i][TAG_W-1];
        end
    end

endmodule

// File: rtl/bicubic_tap_arbiter.sv
// Grants two tap requesters whole bursts on a shared multiply-add datapath
// (round robin between bursts) and routes the delayed results back by owner.
module bicubic_tap_arbiter
    import bicubic_sched_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int BURST   = DEF_BURST
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             x_valid,
    output logic             x_ready,
    input  logic [A_W-1:0]   x_a,
    input  logic [B_W-1:0]   x_b,
    input  logic [C_W-1:0]   x_c,
    input  logic [D_W-1:0]   x_d,

    input  logic             y_valid,
    output logic             y_ready,
    input  logic [A_W-1:0]   y_a,
    input  logic [B_W-1:0]   y_b,
    input  logic [C_W-1:0]   y_c,
    input  logic [D_W-1:0]   y_d,

    output logic [A_W-1:0]   ma_a,
    output logic [B_W-1:0]   ma_b,
    output logic [C_W-1:0]   ma_c,
    output logic [D_W-1:0]   ma_d,
    input  logic [R_W-1:0]   ma_result,

    output logic             x_res_valid,
    output logic [R_W-1:0]   x_res_data,
    output logic [TAP_W-1:0] x_res_tap,
    output logic             x_done,

    output logic             y_res_valid,
    output logic [R_W-1:0]   y_res_data,
    output logic [TAP_W-1:0] y_res_tap,
    output logic             y_done,

    output logic             busy
);

    // Tap numbers are TAP_W bits wide, so BURST is expected to be 2..4.
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(BURST - 1);

    sched_state_t     state, state_nxt;
    logic [TAP_W-1:0] beat_cnt, beat_cnt_nxt;
    owner_t           rr, rr_nxt;

    logic             x_acc, y_acc, beat_acc, last_beat;
    logic [TAG_W-1:0] tag_in, tag_out;
    tag_t             tail;
    logic             tags_busy;

    assign x_acc     = x_ready & x_valid;
    assign y_acc     = y_ready & y_valid;
    assign beat_acc  = x_acc | y_acc;
    assign last_beat = beat_acc && (beat_cnt == LAST_TAP);

    // A kept grant (same requester continuing) that sees no beat on its first
    // cycle is released, so the arbiter can drain back to IDLE.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        rr_nxt       = rr;
        case (state)
            ST_IDLE: begin
                if (x_valid && (!y_valid || rr == OWNER_Y)) begin
                    state_nxt = ST_OWN_X;
                end else if (y_valid) begin
                    state_nxt = ST_OWN_Y;
                end
            end
            ST_OWN_X: begin
                if (x_acc) begin
                    if (last_beat) begin
                        beat_cnt_nxt = '0;
                        rr_nxt       = OWNER_X;
                        if (y_valid) begin
                            state_nxt = ST_OWN_Y;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + TAP_W'(1);
                    end
                end else if (beat_cnt == '0) begin
                    state_nxt = y_valid ? ST_OWN_Y : ST_IDLE;
                end
            end
            ST_OWN_Y: begin
                if (y_acc) begin
                    if (last_beat) begin
                        beat_cnt_nxt = '0;
                        rr_nxt       = OWNER_Y;
                        if (x_valid) begin
                            state_nxt = ST_OWN_X;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + TAP_W'(1);
                    end
                end else if (beat_cnt == '0) begin
                    state_nxt = x_valid ? ST_OWN_X : ST_IDLE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            rr       <= OWNER_Y;
            x_ready  <= 1'b0;
            y_ready  <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr       <= rr_nxt;
            x_ready  <= (state_nxt == ST_OWN_X);
            y_ready  <= (state_nxt == ST_OWN_Y);
        end
    end

    always_comb begin
        ma_a = '0;
        ma_b = '0;
        ma_c = '0;
        ma_d = '0;
        if (x_acc) begin
            ma_a = x_a;
            ma_b = x_b;
            ma_c = x_c;
            ma_d = x_d;
        end else if (y_acc) begin
            ma_a = y_a;
            ma_b = y_b;
            ma_c = y_c;
            ma_d = y_d;
        end
    end

    assign tag_in = make_tag(beat_acc, y_acc ? OWNER_Y : OWNER_X, beat_cnt);

    sched_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_busy)
    );

    assign tail = tag_t'(tag_out);

    // The tag tail lines up with ma_result; capture it for the owning side only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_res_valid <= 1'b0;
            x_res_data  <= '0;
            x_res_tap   <= '0;
            x_done      <= 1'b0;
            y_res_valid <= 1'b0;
            y_res_data  <= '0;
            y_res_tap   <= '0;
            y_done      <= 1'b0;
        end else begin
            x_res_valid <= tail.valid && (tail.owner == OWNER_X);
            y_res_valid <= tail.valid && (tail.owner == OWNER_Y);
            x_done      <= tail.valid && (tail.owner == OWNER_X) && (tail.tap == LAST_TAP);
            y_done      <= tail.valid && (tail.owner == OWNER_Y) && (tail.tap == LAST_TAP);
            if (tail.valid && tail.owner == OWNER_X) begin
                x_res_data <= ma_result;
                x_res_tap  <= tail.tap;
            end
            if (tail.valid && tail.owner == OWNER_Y) begin
                y_res_data <= ma_result;
                y_res_tap  <= tail.tap;
            end
        end
    end

    assign busy = (state != ST_IDLE) | tags_busy;

endmodule

// File: doc/bicubic_tap_arbiter.md
BICUBIC_TAP_ARBITER -- requirements
Module: bicubic_tap_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from operand presentation on ma_* to valid ma_result.
REQ-002 SHALL have parameter BURST, default 4: operand beats per request burst, one per bicubic tap.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports x_valid/y_valid, input, 1 bit each: requester has an operand beat.
REQ-006 SHALL have ports x_ready/y_ready, output, 1 bit each: beat accepted when valid&ready.
REQ-007 SHALL have ports x_a/y_a 40b, x_b/y_b 38b, x_c/y_c 28b, x_d/y_d 18b, inputs: operand sets.
REQ-008 SHALL have ports ma_a 40b, ma_b 38b, ma_c 28b, ma_d 18b, outputs: operands to the shared multiply-add datapath.
REQ-009 SHALL have port ma_result, input, 17 bits: datapath result.
REQ-010 SHALL have ports x_res_valid/y_res_valid, output, 1b; x_res_data/y_res_data, output, 17b; x_res_tap/y_res_tap, output, 2b: per-owner results.
REQ-011 SHALL have ports x_done/y_done, output, 1b: pulse with the tap BURST-1 result.
REQ-012 SHALL have port busy, output, 1b: burst owned or any beat in flight.

Function
REQ-013 SHALL implement FSM IDLE, OWN_X, OWN_Y; x_ready=1 only in OWN_X, y_ready=1 only in OWN_Y.
REQ-014 IDLE: x_valid only -> OWN_X; y_valid only -> OWN_Y; both -> requester not granted last (rr pointer, reset value Y so X wins first).
REQ-015 Grant is locked for a full burst; beat counter 0..BURST-1 advances only on accepted beat; valid low mid-burst inserts bubbles, no switch.
REQ-016 On last beat accepted: other requester valid -> switch to it with no bubble; else same requester valid -> keep; else IDLE; rr pointer = finishing owner.
REQ-017 ma_* SHALL be combinational mux of granted operands when a beat is accepted, else all zero.
REQ-018 Tag delay line, LATENCY stages, carries {valid, owner, tap} per accepted beat; one entry per cycle max.
REQ-019 Tag tail valid SHALL register ma_result into owner's res_data, res_tap=tap, res_valid=1 for one cycle; accepted beat in cycle T -> owner res_valid in cycle T+LATENCY+1.
REQ-020 done SHALL pulse in same cycle as res_valid with tap BURST-1; other owner's res_valid stays 0.
REQ-021 res_data/res_tap SHALL hold last value when res_valid=0.
REQ-022 busy = (state!=IDLE) OR any tag stage valid, registered-free combinational.
REQ-023 Back-to-back bursts SHALL sustain one beat per cycle; no result backpressure exists.

Reset
REQ-024 rst asserted at any time: state IDLE, beat counter 0, rr pointer Y, all tag stages invalid, all res_valid/done 0, res_data 0, res_tap 0.
REQ-025 Reset mid-burst SHALL discard in-flight beats; no res_valid for them after release.
REQ-026 First grant possible in first cycle after rst deasserts.

Structure
REQ-027 Package bicubic_sched_pkg SHALL hold LATENCY/BURST defaults, operand width constants (40/38/28/18/17), FSM state encoding, owner encoding (X=0,Y=1).
REQ-028 Tag delay line SHALL be sub-module sched_tag_pipe (parameter LATENCY, width 1+1+2).
REQ-029 The multiply-add datapath is external; bench instantiates it on ma_*.

Verification
REQ-030 x_valid held, 4 beats a=0x100000000,b=c=d=0 -> x_ready cycles 0-3, x_res_valid cycles 4-7 taps 0..3, data 0x0100, x_done at cycle 7.
REQ-031 x_valid,y_valid both high from reset -> X burst 4 beats, Y burst next 4 with no bubble, then X again; rr alternates.
REQ-032 x_valid dropped at beat 2 for 3 cycles, y_valid high -> y_ready stays 0, X burst resumes, tap numbering continuous 0..3.
REQ-033 rst pulsed one cycle after beat 2 accepted -> no res_valid/done for in-flight beats, busy=0 after reset, IDLE.
REQ-034 Random operand sets both requesters, 1000 bursts -> every result matches datapath model, routed to correct owner and tap, busy=0 when drained.
